spart_echo_master: RTL
======================

SPART_ECHO_MASTER -- requirements
Module: spart_echo_master

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 13'h0A2C, the 13-bit divisor (19200 baud at 50 MHz) programmed after reset.
REQ-002 SHALL have port clk  in  1  system clock (50 MHz); the only clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port enable  in  1  high permits polling/echo; low holds in IDLE after configuration.
REQ-005 SHALL have port rx_q_empty  in  1  SPART RX queue empty.
REQ-006 SHALL have port tx_q_full  in  1  SPART TX queue full.
REQ-007 SHALL have port iocs_n  out  1  active-low chip select to SPART.
REQ-008 SHALL have port iorw_n  out  1  high read, low write.
REQ-009 SHALL have port ioaddr  out  2  register select: 00 DBUF, 01 SREG, 10 DBL, 11 DBH.
REQ-010 SHALL have port databus  inout  8  bidirectional data bus.
REQ-011 SHALL have port echo_cnt  out  16  count of bytes echoed.
REQ-012 SHALL have port last_byte  out  8  most recent byte echoed.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL use the FSM states CFG_DBL, CFG_DBH, IDLE, POLL, RD_DATA and WR_DATA; bus outputs SHALL be a pure decode of the registered state.
REQ-015 Each bus access SHALL last exactly one cycle, with iocs_n=0 for that whole cycle.
REQ-016 Read data SHALL be sampled from databus at the posedge that ends the access cycle.
REQ-017 CFG_DBL SHALL write BAUD_DIV[7:0] to addr 10, then go unconditionally to CFG_DBH.
REQ-018 CFG_DBH SHALL write {3'b000, BAUD_DIV[12:8]} to addr 11, then go to IDLE.
REQ-019 In IDLE, iocs_n=1; when enable=1, rx_q_empty=0 and tx_q_full=0 the next state SHALL be POLL, otherwise IDLE.
REQ-020 POLL SHALL read addr 01 into sreg_q; SREG[7:4] = TX free entries and SREG[3:0] = RX occupied entries.
REQ-021 After POLL: if sreg[3:0]!=0 and sreg[7:4]!=0 -> RD_DATA, else -> IDLE.
REQ-022 RD_DATA SHALL read addr 00 into data_q, then go to WR_DATA.
REQ-023 WR_DATA SHALL write data_q to addr 00, then go to IDLE.
REQ-024 At that WR_DATA exit, echo_cnt SHALL increment (16-bit, 16'hFFFF wraps to 0) and last_byte SHALL load data_q.
REQ-025 databus SHALL be driven only in CFG_DBL, CFG_DBH and WR_DATA; otherwise it is high-Z.
REQ-026 Every access SHALL be followed by at least one cycle with iocs_n=1 (IDLE) before the next POLL, for bus turnaround.
REQ-027 Minimum echo sequence: IDLE -> POLL -> RD_DATA -> WR_DATA -> IDLE, i.e. 4 cycles per byte.
REQ-028 enable deasserted mid-sequence SHALL NOT abort it; the sequence completes and the FSM then holds in IDLE.
REQ-029 When rx_q_empty=0 but SREG[3:0]=0 (stale flag), the FSM SHALL return to IDLE without touching DBUF.
REQ-030 No DBUF read SHALL occur unless the immediately preceding POLL showed TX space, so the TX queue can never overflow.

Reset
REQ-031 While rst=1, the outputs SHALL be iocs_n=1, iorw_n=1, ioaddr=00, databus high-Z, echo_cnt=0, last_byte=0 and busy=1.
REQ-032 While rst=1, state SHALL be CFG_DBL and sreg_q/data_q SHALL be 0.
REQ-033 The first cycle after rst falls SHALL be the CFG_DBL write.
REQ-034 rst asserted during any access SHALL release the bus (iocs_n=1, databus high-Z) in the cycle after the rst posedge; a partial echo SHALL NOT count.

Structure
REQ-035 The shared package spart_pkg SHALL hold ADDR_DBUF/ADDR_SREG/ADDR_DBL/ADDR_DBH (2'b00..2'b11), the QUEUE_SIZE=8 constant and the state enum type.
REQ-036 The block SHALL be a single module with no sub-modules; the tri-state driver SHALL be a single continuous assignment.

Verification
REQ-037 Reset release: bench SHALL see a write of 8'h2C to addr 10, then a write of 8'h0A to addr 11 on consecutive cycles, then iocs_n=1.
REQ-038 One byte 8'hA5 sent into the SPART at 19200 baud: bench SHALL see POLL, RD, WR of A5 to DBUF; spart TX SHALL emit A5; echo_cnt=1 and last_byte=A5.
REQ-039 12 back-to-back bytes on RX with TX throttled so tx_q_full is asserted: bench SHALL see no DBUF read while tx_q_full=1 or SREG[7:4]=0, all 12 bytes emitted in order, and echo_cnt=12.
REQ-040 enable=0 with RX data pending: bench SHALL see no access after configuration; after enable=1 the echo SHALL resume within 2 cycles.
REQ-041 rst pulsed during WR_DATA: bench SHALL see iocs_n=1 the next cycle, echo_cnt=0, and configuration rewritten.
REQ-042 echo_cnt preloaded via force to 16'hFFFF, then one echo: bench SHALL see echo_cnt=16'h0000.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART echo master: register map, queue depth,
// controller state encoding and the status-register decode helper.
package spart_pkg;

  localparam logic [1:0] ADDR_DBUF = 2'b00;
  localparam logic [1:0] ADDR_SREG = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int QUEUE_SIZE = 8;

  typedef enum logic [2:0] {
    CFG_DBL,
    CFG_DBH,
    IDLE,
    POLL,
    RD_DATA,
    WR_DATA
  } state_t;

  // SREG[7:4] = TX free entries, SREG[3:0] = RX occupied entries.
  // An echo is only safe when there is both a byte to read and room to send it.
  function automatic logic sreg_can_echo(input logic [7:0] sreg);
    return (sreg[7:4] != 4'd0) && (sreg[3:0] != 4'd0);
  endfunction

endpackage

// File: rtl/spart_echo_master.sv
// SPART echo master: programs the baud divisor after reset, then polls the
// SPART status register and echoes every received byte back to the TX queue.
//
// state   | meaning
// --------+-----------------------------------------------------------
// CFG_DBL | write divisor low byte to DBL
// CFG_DBH | write divisor high bits to DBH
// IDLE    | bus released; wait for enable, RX data and TX space
// POLL    | read SREG; continue only if RX has data and TX has room
// RD_DATA | read one received byte from DBUF
// WR_DATA | write that byte back to DBUF; count it
import spart_pkg::*;

module spart_echo_master #(
  parameter logic [12:0] BAUD_DIV = 13'h0A2C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rx_q_empty,
  input  logic        tx_q_full,
  output logic        iocs_n,
  output logic        iorw_n,
  output logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  output logic [15:0] echo_cnt,
  output logic [7:0]  last_byte,
  output logic        busy
);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_sreg_q;
  logic [7:0]  r_data_q;
  logic [15:0] r_echo_cnt;
  logic [7:0]  r_last_byte;

  logic        w_cs;
  logic        w_rd;
  logic        w_drive;
  logic [1:0]  w_addr;
  logic [7:0]  w_wdata;

  // State register; reset parks the controller on the first config write.
  always_ff @(posedge clk) begin
    if (rst) r_state <= CFG_DBL;
    else     r_state <= w_next;
  end

  // Capture read data at the edge closing each read; count completed echoes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg_q    <= 8'h00;
      r_data_q    <= 8'h00;
      r_echo_cnt  <= 16'h0000;
      r_last_byte <= 8'h00;
    end else begin
      case (r_state)
        POLL:    r_sreg_q <= databus;
        RD_DATA: r_data_q <= databus;
        WR_DATA: begin
          r_echo_cnt  <= r_echo_cnt + 16'd1;
          r_last_byte <= r_data_q;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic. The POLL exit decides on the live bus value so a full
  // echo takes four cycles; the registered SREG copy backs up the RD_DATA exit.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CFG_DBL: w_next = CFG_DBH;
      CFG_DBH: w_next = IDLE;
      IDLE:    if (enable && !rx_q_empty && !tx_q_full) w_next = POLL;
      POLL:    w_next = sreg_can_echo(databus) ? RD_DATA : IDLE;
      RD_DATA: w_next = sreg_can_echo(r_sreg_q) ? WR_DATA : IDLE;
      WR_DATA: w_next = IDLE;
      default: w_next = CFG_DBL;
    endcase
  end

  // Bus cycle decode from the registered state only.
  always_comb begin
    w_cs    = 1'b0;
    w_rd    = 1'b1;
    w_drive = 1'b0;
    w_addr  = ADDR_DBUF;
    w_wdata = 8'h00;
    unique case (r_state)
      CFG_DBL: begin
        w_cs = 1'b1; w_rd = 1'b0; w_drive = 1'b1;
        w_addr = ADDR_DBL; w_wdata = BAUD_DIV[7:0];
      end
      CFG_DBH: begin
        w_cs = 1'b1; w_rd = 1'b0; w_drive = 1'b1;
        w_addr = ADDR_DBH; w_wdata = {3'b000, BAUD_DIV[12:8]};
      end
      POLL: begin
        w_cs = 1'b1; w_addr = ADDR_SREG;
      end
      RD_DATA: begin
        w_cs = 1'b1; w_addr = ADDR_DBUF;
      end
      WR_DATA: begin
        w_cs = 1'b1; w_rd = 1'b0; w_drive = 1'b1;
        w_addr = ADDR_DBUF; w_wdata = r_data_q;
      end
      default: ;
    endcase
  end

  // Reset overrides the decode so an interrupted access releases the bus at once.
  assign iocs_n    = rst | ~w_cs;
  assign iorw_n    = rst | w_rd;
  assign ioaddr    = rst ? ADDR_DBUF : w_addr;
  assign databus   = (w_drive && !rst) ? w_wdata : 8'hzz;
  assign echo_cnt  = r_echo_cnt;
  assign last_byte = r_last_byte;
  assign busy      = rst | (r_state != IDLE);

endmodule
